// File: rtl/dispatch_unit.sv
// In-order dispatch stage: holds one decoded instruction, allocates a station tag,
// reads and bypasses operands, renames rd and issues to the ALU, branch or LS station.
module dispatch_unit #(
  parameter int IDX_W  = 4,
  parameter int ALU_RS = 16,
  parameter int LS_RS  = 16,
  parameter int DATA_W = 32,
  parameter int NAME_W = 5,
  parameter int OP_W   = 6,
  localparam int TAG_W = IDX_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [NAME_W-1:0] dec_rs1,
  input  logic [NAME_W-1:0] dec_rs2,
  input  logic [NAME_W-1:0] dec_rd,
  input  logic [OP_W-1:0]   dec_op,
  input  logic [3:0]        dec_class,
  input  logic [DATA_W-1:0] dec_addr,
  input  logic [DATA_W-1:0] dec_imm,
  output logic [NAME_W-1:0] rf_name1,
  output logic [NAME_W-1:0] rf_name2,
  input  logic [TAG_W-1:0]  rf_tag1,
  input  logic [TAG_W-1:0]  rf_tag2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [ALU_RS-1:0] alu_free,
  input  logic [LS_RS-1:0]  ls_free,
  input  logic              br_free,
  output logic              ren_en,
  output logic [NAME_W-1:0] ren_name,
  output logic [TAG_W-1:0]  ren_tag,
  output logic              alu_en,
  output logic              br_en,
  output logic              ls_en,
  output logic [DATA_W-1:0] iss_op1,
  output logic [DATA_W-1:0] iss_op2,
  output logic [TAG_W-1:0]  iss_tag1,
  output logic [TAG_W-1:0]  iss_tag2,
  output logic [TAG_W-1:0]  iss_tagw,
  output logic [NAME_W-1:0] iss_namew,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_imm,
  output logic [DATA_W-1:0] iss_addr
);

  localparam logic [3:0] ClassLUI   = 4'd0;
  localparam logic [3:0] ClassAUIPC = 4'd1;
  localparam logic [3:0] ClassJAL   = 4'd2;
  localparam logic [3:0] ClassJALR  = 4'd3;
  localparam logic [3:0] ClassB     = 4'd4;
  localparam logic [3:0] ClassLD    = 4'd5;
  localparam logic [3:0] ClassST    = 4'd6;
  localparam logic [3:0] ClassRI    = 4'd7;
  localparam logic [3:0] ClassRR    = 4'd8;

  localparam logic [TAG_W-1:0] TagFree = {1'b1, {(TAG_W-1){1'b0}}};

  logic              holdValid_q, holdValid_d;
  logic [NAME_W-1:0] holdRs1_q, holdRs2_q, holdRd_q;
  logic [OP_W-1:0]   holdOp_q;
  logic [3:0]        holdClass_q;
  logic [DATA_W-1:0] holdAddr_q, holdImm_q;

  logic              maskValid_q, maskValid_d;
  logic              maskLs_q, maskLs_d;
  logic [IDX_W-1:0]  maskIdx_q, maskIdx_d;

  logic              isAlu, isBr, isLs, use1, use2, writesRd;
  logic [ALU_RS-1:0] aluEff;
  logic [LS_RS-1:0]  lsEff;
  logic [IDX_W-1:0]  aluIdx, lsIdx;
  logic              resourceOk, fire, accept;
  logic [TAG_W-1:0]  allocTag, tagW;
  logic [DATA_W-1:0] op1Data, op2Data;
  logic [TAG_W-1:0]  op1Tag, op2Tag;

  assign rf_name1 = holdRs1_q;
  assign rf_name2 = holdRs2_q;

  always_comb begin
    isAlu    = 1'b0;
    isBr     = 1'b0;
    isLs     = 1'b0;
    use1     = 1'b0;
    use2     = 1'b0;
    writesRd = 1'b0;
    case (holdClass_q)
      ClassLUI, ClassAUIPC, ClassJAL: begin
        isAlu    = 1'b1;
        writesRd = 1'b1;
      end
      ClassJALR, ClassRI: begin
        isAlu    = 1'b1;
        use1     = 1'b1;
        writesRd = 1'b1;
      end
      ClassRR: begin
        isAlu    = 1'b1;
        use1     = 1'b1;
        use2     = 1'b1;
        writesRd = 1'b1;
      end
      ClassB: begin
        isBr = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      ClassLD: begin
        isLs     = 1'b1;
        use1     = 1'b1;
        writesRd = 1'b1;
      end
      ClassST: begin
        isLs = 1'b1;
        use1 = 1'b1;
        use2 = 1'b1;
      end
      default: ;
    endcase
  end

  // Station free vectors lag a cycle, so last cycle's allocation is hidden here
  always_comb begin
    aluEff = alu_free;
    lsEff  = ls_free;
    if (maskValid_q && !maskLs_q) aluEff = alu_free & ~({{(ALU_RS-1){1'b0}}, 1'b1} << maskIdx_q);
    if (maskValid_q && maskLs_q)  lsEff  = ls_free & ~({{(LS_RS-1){1'b0}}, 1'b1} << maskIdx_q);
    aluIdx = '0;
    lsIdx  = '0;
    for (int i = ALU_RS - 1; i >= 0; i--) begin
      if (aluEff[i]) aluIdx = IDX_W'(i);
    end
    for (int i = LS_RS - 1; i >= 0; i--) begin
      if (lsEff[i]) lsIdx = IDX_W'(i);
    end
  end

  always_comb begin
    if (isAlu)     resourceOk = |aluEff;
    else if (isLs) resourceOk = |lsEff;
    else if (isBr) resourceOk = br_free;
    else           resourceOk = 1'b1;
    fire      = holdValid_q && !flush && resourceOk;
    dec_ready = (!holdValid_q || fire) && !flush;
    accept    = dec_valid && dec_ready;
    allocTag  = isLs ? {1'b0, 1'b1, lsIdx} : {1'b0, 1'b0, aluIdx};
    tagW      = writesRd ? allocTag : TagFree;
  end

  always_comb begin
    op1Data = '0;
    op1Tag  = TagFree;
    op2Data = '0;
    op2Tag  = TagFree;
    if (use1) begin
      if (cdb_valid && cdb_tag == rf_tag1) op1Data = cdb_data;
      else begin
        op1Data = rf_data1;
        op1Tag  = rf_tag1;
      end
    end
    if (use2) begin
      if (cdb_valid && cdb_tag == rf_tag2) op2Data = cdb_data;
      else begin
        op2Data = rf_data2;
        op2Tag  = rf_tag2;
      end
    end
  end

  always_comb begin
    holdValid_d = holdValid_q;
    if (fire)   holdValid_d = 1'b0;
    if (accept) holdValid_d = 1'b1;
    if (flush)  holdValid_d = 1'b0;
    maskValid_d = fire && (isAlu || isLs);
    maskLs_d    = isLs;
    maskIdx_d   = isLs ? lsIdx : aluIdx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdValid_q <= 1'b0;
      holdRs1_q   <= '0;
      holdRs2_q   <= '0;
      holdRd_q    <= '0;
      holdOp_q    <= '0;
      holdClass_q <= '0;
      holdAddr_q  <= '0;
      holdImm_q   <= '0;
      maskValid_q <= 1'b0;
      maskLs_q    <= 1'b0;
      maskIdx_q   <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      maskValid_q <= maskValid_d;
      maskLs_q    <= maskLs_d;
      maskIdx_q   <= maskIdx_d;
      if (accept) begin
        holdRs1_q   <= dec_rs1;
        holdRs2_q   <= dec_rs2;
        holdRd_q    <= dec_rd;
        holdOp_q    <= dec_op;
        holdClass_q <= dec_class;
        holdAddr_q  <= dec_addr;
        holdImm_q   <= dec_imm;
      end
    end
  end

  // Strobes last one cycle; issue payload is only refreshed when something fires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_en    <= 1'b0;
      br_en     <= 1'b0;
      ls_en     <= 1'b0;
      ren_en    <= 1'b0;
      ren_name  <= '0;
      ren_tag   <= TagFree;
      iss_op1   <= '0;
      iss_op2   <= '0;
      iss_tag1  <= TagFree;
      iss_tag2  <= TagFree;
      iss_tagw  <= TagFree;
      iss_namew <= '0;
      iss_op    <= '0;
      iss_imm   <= '0;
      iss_addr  <= '0;
    end else begin
      alu_en <= fire && isAlu;
      br_en  <= fire && isBr;
      ls_en  <= fire && isLs;
      ren_en <= fire && writesRd && (holdRd_q != '0);
      if (fire) begin
        ren_name  <= holdRd_q;
        ren_tag   <= tagW;
        iss_op1   <= op1Data;
        iss_op2   <= op2Data;
        iss_tag1  <= op1Tag;
        iss_tag2  <= op2Tag;
        iss_tagw  <= tagW;
        iss_namew <= holdRd_q;
        iss_op    <= holdOp_q;
        iss_imm   <= holdImm_q;
        iss_addr  <= holdAddr_q;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: stimulus pushes expected issues into a queue,
// a negedge monitor pops and compares whenever an issue strobe appears.
module tb_dispatch_unit;

  localparam logic [3:0] CLUI = 4'd0, CAUIPC = 4'd1, CJAL = 4'd2, CJALR = 4'd3, CB = 4'd4;
  localparam logic [3:0] CLD = 4'd5, CST = 4'd6, CRI = 4'd7, CRR = 4'd8, CNOP = 4'd15;
  localparam logic [5:0] TFREE = 6'h20;
  localparam logic [31:0] D1 = 32'h1111_1111, D2 = 32'h2222_2222;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic dec_valid = 1'b0, dec_ready;
  logic [4:0] dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic [5:0] dec_op = '0;
  logic [3:0] dec_class = '0;
  logic [31:0] dec_addr = '0, dec_imm = '0;
  logic [4:0] rf_name1, rf_name2;
  logic [5:0] rf_tag1 = TFREE, rf_tag2 = TFREE;
  logic [31:0] rf_data1 = D1, rf_data2 = D2;
  logic cdb_valid = 1'b0;
  logic [5:0] cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic [15:0] alu_free = 16'hFFFF, ls_free = 16'hFFFF;
  logic br_free = 1'b1;
  logic ren_en, alu_en, br_en, ls_en;
  logic [4:0] ren_name, iss_namew;
  logic [5:0] ren_tag, iss_tag1, iss_tag2, iss_tagw, iss_op;
  logic [31:0] iss_op1, iss_op2, iss_imm, iss_addr;

  typedef struct {
    int          kind;
    logic [31:0] op1;
    logic [5:0]  tag1;
    logic [31:0] op2;
    logic [5:0]  tag2;
    logic [5:0]  tagw;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        renEn;
  } issue_t;

  issue_t expQ[$];
  int checks = 0;
  int errors = 0;

  dispatch_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_op(dec_op), .dec_class(dec_class), .dec_addr(dec_addr), .dec_imm(dec_imm),
    .rf_name1(rf_name1), .rf_name2(rf_name2),
    .rf_tag1(rf_tag1), .rf_tag2(rf_tag2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_free(alu_free), .ls_free(ls_free), .br_free(br_free),
    .ren_en(ren_en), .ren_name(ren_name), .ren_tag(ren_tag),
    .alu_en(alu_en), .br_en(br_en), .ls_en(ls_en),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .iss_tag1(iss_tag1), .iss_tag2(iss_tag2),
    .iss_tagw(iss_tagw), .iss_namew(iss_namew), .iss_op(iss_op),
    .iss_imm(iss_imm), .iss_addr(iss_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] cls, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [5:0] op,
                               input logic [31:0] imm, input logic [31:0] addr);
    dec_valid = 1'b1;
    dec_class = cls;
    dec_rs1   = rs1;
    dec_rs2   = rs2;
    dec_rd    = rd;
    dec_op    = op;
    dec_imm   = imm;
    dec_addr  = addr;
  endtask

  task automatic expectIssue(input int kind, input logic [31:0] op1, input logic [5:0] tag1,
                             input logic [31:0] op2, input logic [5:0] tag2, input logic [5:0] tagw,
                             input logic renEn);
    issue_t e;
    e.kind = kind; e.op1 = op1; e.tag1 = tag1; e.op2 = op2; e.tag2 = tag2; e.tagw = tagw;
    e.rd = dec_rd; e.op = dec_op; e.imm = dec_imm; e.addr = dec_addr; e.renEn = renEn;
    expQ.push_back(e);
  endtask

  // Monitor: every issue strobe must match the oldest expected issue
  always @(negedge clk) begin
    if (!rst && (alu_en || br_en || ls_en)) begin
      checkOutput("strobe_onehot", 64'(alu_en) + 64'(br_en) + 64'(ls_en), 64'd1);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_issue", 64'(iss_tagw), 64'hFFFF);
      end else begin
        issue_t e;
        e = expQ.pop_front();
        checkOutput("kind", alu_en ? 64'd0 : (br_en ? 64'd1 : 64'd2), 64'(e.kind));
        checkOutput("iss_op1", 64'(iss_op1), 64'(e.op1));
        checkOutput("iss_tag1", 64'(iss_tag1), 64'(e.tag1));
        checkOutput("iss_op2", 64'(iss_op2), 64'(e.op2));
        checkOutput("iss_tag2", 64'(iss_tag2), 64'(e.tag2));
        checkOutput("iss_tagw", 64'(iss_tagw), 64'(e.tagw));
        checkOutput("iss_namew", 64'(iss_namew), 64'(e.rd));
        checkOutput("iss_op", 64'(iss_op), 64'(e.op));
        checkOutput("iss_imm", 64'(iss_imm), 64'(e.imm));
        checkOutput("iss_addr", 64'(iss_addr), 64'(e.addr));
        checkOutput("ren_en", 64'(ren_en), 64'(e.renEn));
        if (e.renEn) begin
          checkOutput("ren_name", 64'(ren_name), 64'(e.rd));
          checkOutput("ren_tag", 64'(ren_tag), 64'(e.tagw));
        end
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_strobes"}, {60'd0, alu_en, br_en, ls_en, ren_en}, 64'd0);
    checkOutput({tag, "_tags"}, {iss_tag1, iss_tag2, iss_tagw, ren_tag}, {TFREE, TFREE, TFREE, TFREE});
    checkOutput({tag, "_op1"}, 64'(iss_op1), 64'd0);
    checkOutput({tag, "_addr"}, 64'(iss_addr), 64'd0);
    checkOutput({tag, "_imm"}, 64'(iss_imm), 64'd0);
    checkOutput({tag, "_names"}, {iss_op, iss_namew, ren_name, rf_name1}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    tick();
    peek();
    checkResetState("reset");
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back RR: tags 0x00 then 0x01 on consecutive cycles
    applyStimulus(CRR, 5'd2, 5'd3, 5'd1, 6'h01, 32'h0, 32'h100);
    expectIssue(0, D1, TFREE, D2, TFREE, 6'h00, 1'b1);
    tick();
    applyStimulus(CRR, 5'd4, 5'd5, 5'd2, 6'h02, 32'h0, 32'h104);
    expectIssue(0, D1, TFREE, D2, TFREE, 6'h01, 1'b1);
    peek();
    checkOutput("b2b_ready", 64'(dec_ready), 64'd1);
    tick();
    dec_valid = 1'b0;
    peek();
    checkOutput("b2b_first_alu_en", 64'(alu_en), 64'd1);
    tick();
    peek();
    checkOutput("b2b_second_alu_en", 64'(alu_en), 64'd1);
    tick();
    peek();
    checkOutput("b2b_idle_alu_en", 64'(alu_en), 64'd0);

    // ALU full stall, then a single free entry at index 8
    tick();
    alu_free = 16'h0000;
    applyStimulus(CRI, 5'd6, 5'd7, 5'd4, 6'h03, 32'h0000_0ABC, 32'h108);
    tick();
    dec_valid = 1'b0;
    peek();
    checkOutput("full_ready", 64'(dec_ready), 64'd0);
    checkOutput("full_alu_en", 64'(alu_en), 64'd0);
    tick();
    peek();
    checkOutput("full_ready2", 64'(dec_ready), 64'd0);
    checkOutput("full_alu_en2", 64'(alu_en), 64'd0);
    checkOutput("full_held_rs1", 64'(rf_name1), 64'd6);
    tick();
    dec_rd = 5'd4; dec_op = 6'h03; dec_imm = 32'h0000_0ABC; dec_addr = 32'h108;
    expectIssue(0, D1, TFREE, 32'h0, TFREE, 6'h08, 1'b1);
    alu_free = 16'h0100;
    tick();
    peek();
    checkOutput("full_release_alu_en", 64'(alu_en), 64'd1);
    tick();
    alu_free = 16'hFFFF;

    // LD then ST with ls_free=0006
    ls_free = 16'h0006;
    applyStimulus(CLD, 5'd8, 5'd9, 5'd5, 6'h04, 32'h40, 32'h200);
    expectIssue(2, D1, TFREE, 32'h0, TFREE, 6'h11, 1'b1);
    tick();
    applyStimulus(CST, 5'd10, 5'd11, 5'd12, 6'h05, 32'h44, 32'h204);
    expectIssue(2, D1, TFREE, D2, TFREE, TFREE, 1'b0);
    tick();
    dec_valid = 1'b0;
    peek();
    checkOutput("ld_ls_en", 64'(ls_en), 64'd1);
    tick();
    peek();
    checkOutput("st_ls_en", 64'(ls_en), 64'd1);
    tick();
    ls_free = 16'hFFFF;

    // Branch stalls on br_free
    br_free = 1'b0;
    applyStimulus(CB, 5'd1, 5'd2, 5'd0, 6'h06, 32'h80, 32'h300);
    expectIssue(1, D1, TFREE, D2, TFREE, TFREE, 1'b0);
    tick();
    dec_valid = 1'b0;
    peek();
    checkOutput("br_stall_ready", 64'(dec_ready), 64'd0);
    checkOutput("br_stall_en", 64'(br_en), 64'd0);
    tick();
    br_free = 1'b1;
    tick();
    peek();
    checkOutput("br_en", 64'(br_en), 64'd1);
    tick();

    // CDB bypass on operand 1 in the fire cycle; operand 2 keeps its tag
    rf_tag1 = 6'h03;
    rf_tag2 = 6'h05;
    applyStimulus(CRR, 5'd3, 5'd4, 5'd7, 6'h07, 32'h0, 32'h400);
    expectIssue(0, 32'hDEAD_BEEF, TFREE, D2, 6'h05, 6'h00, 1'b1);
    tick();
    dec_valid = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 6'h03;
    cdb_data  = 32'hDEAD_BEEF;
    tick();
    cdb_valid = 1'b0;
    rf_tag1 = TFREE;
    rf_tag2 = TFREE;
    peek();
    checkOutput("cdb_alu_en", 64'(alu_en), 64'd1);
    tick();

    // JAL with rd=0: issues, no rename
    applyStimulus(CJAL, 5'd0, 5'd0, 5'd0, 6'h08, 32'h10, 32'h500);
    expectIssue(0, 32'h0, TFREE, 32'h0, TFREE, 6'h00, 1'b0);
    tick();
    dec_valid = 1'b0;
    tick();
    peek();
    checkOutput("jal_alu_en", 64'(alu_en), 64'd1);
    checkOutput("jal_ren_en", 64'(ren_en), 64'd0);
    tick();

    // Unknown class is consumed silently
    applyStimulus(CNOP, 5'd1, 5'd1, 5'd1, 6'h09, 32'h0, 32'h600);
    tick();
    dec_valid = 1'b0;
    peek();
    checkOutput("nop_ready", 64'(dec_ready), 64'd1);
    tick();
    peek();
    checkOutput("nop_strobes", {61'd0, alu_en, br_en, ls_en}, 64'd0);
    checkOutput("nop_ren", 64'(ren_en), 64'd0);

    // Flush wins over fire; an instruction offered during flush is dropped
    tick();
    applyStimulus(CRR, 5'd1, 5'd2, 5'd9, 6'h0A, 32'h0, 32'h700);
    tick();
    flush = 1'b1;
    applyStimulus(CRR, 5'd3, 5'd4, 5'd10, 6'h0B, 32'h0, 32'h704);
    peek();
    checkOutput("flush_ready", 64'(dec_ready), 64'd0);
    tick();
    flush = 1'b0;
    dec_valid = 1'b0;
    peek();
    checkOutput("flush_no_issue", {60'd0, alu_en, br_en, ls_en, ren_en}, 64'd0);
    checkOutput("flush_stage_empty", 64'(dec_ready), 64'd1);
    tick();
    peek();
    checkOutput("flush_no_issue2", 64'(alu_en), 64'd0);

    // Asynchronous reset in the middle of a stall
    tick();
    alu_free = 16'h0000;
    applyStimulus(CRI, 5'd13, 5'd0, 5'd14, 6'h0C, 32'h5, 32'h800);
    tick();
    dec_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    tick();
    rst = 1'b0;
    alu_free = 16'hFFFF;
    tick();
    peek();
    checkOutput("after_reset_no_issue", 64'(alu_en), 64'd0);
    tick();
    peek();
    checkOutput("after_reset_no_issue2", 64'(alu_en), 64'd0);

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
